ram_window_reader: RTL and testbench
====================================

Name: ram_window_reader

Overview:
- Read-side initiator for the ipgu single-port pixel RAM.
- Accepts a window origin (x, y) and issues raster-order reads of a fixed WIN_W x WIN_H window over the {addr_y, addr_x} RAM port.
- Absorbs the RAM's one-cycle read latency and streams pixels out on a valid/ready interface to the downstream window consumer.
- Never writes the RAM.

Parameters:
- DATA_WIDTH, 8, pixel width; must match the RAM.
- DEPTH_X, 300, RAM columns.
- DEPTH_Y, 300, RAM rows.
- ADDR_WIDTH_X, $clog2(DEPTH_X), column address width.
- ADDR_WIDTH_Y, $clog2(DEPTH_Y), row address width.
- WIN_W, 20, window width in pixels.
- WIN_H, 20, window height in pixels.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a window read; sampled only in IDLE.
- org_x  in  ADDR_WIDTH_X  window left column; sampled with start.
- org_y  in  ADDR_WIDTH_Y  window top row; sampled with start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last pixel handshake.
- err  out  1  one-cycle pulse when a start is rejected as out of bounds.
- ram_addr  out  ADDR_WIDTH_X+ADDR_WIDTH_Y  {row, col} address to the RAM.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  tied 0.
- ram_rdData  in  DATA_WIDTH  RAM read data; valid the cycle after a cs cycle, held while cs is low.
- pix_data  out  DATA_WIDTH  streamed pixel.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  consumer accepts; a transfer occurs when pix_valid & pix_ready.
- pix_last  out  1  high with the final (WIN_W*WIN_H-th) pixel.

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, buffer emptied, any in-flight read discarded.
- States:
  - IDLE: start=1 with org_x+WIN_W<=DEPTH_X and org_y+WIN_H<=DEPTH_Y latches the origin and goes to ISSUE, with busy=1 from the next cycle. start=1 with either bound violated pulses err for 1 cycle, issues no RAM access, and stays IDLE.
  - ISSUE: issues one read per cycle when credit allows. Address order is col org_x..org_x+WIN_W-1, then row+1. The final address goes to DRAIN.
  - DRAIN: no reads issued. When the buffer is empty, no read is in flight, and the last pixel has transferred, pulse done, clear busy, go to IDLE.
- start while busy is ignored and does not affect err.
- Output buffer: 2-entry FIFO. occ = entries + reads in flight (0..2). A read is issued in a cycle only if occ minus this cycle's pop is < 2. Consequences:
  - no RAM data is ever lost;
  - ram_cs is never issued when the read cannot be stored;
  - full 1 pixel/cycle throughput with pix_ready held high.
- Latency: start accepted at edge E0 gives ram_cs=1 in cycle 1, buffer write at E2, and the first pix_valid in cycle 3.
  - With pix_ready high throughout, pix_valid is high for WIN_W*WIN_H consecutive cycles.
  - done pulses the cycle after the last transfer.
- pix_valid/pix_data/pix_last are held stable while pix_valid & !pix_ready.
- Counters:
  - column counter wraps at WIN_W-1 to 0 and increments the row counter;
  - the pixel counter that drives pix_last counts handshakes, not reads;
  - all address arithmetic is unsigned at address width; bounds checks use one extra bit to avoid overflow.
- ram_addr holds its last value when ram_cs=0.

Decomposition:
- ipgu_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN);
  - the default DEPTH_X/DEPTH_Y/WIN_W/WIN_H constants shared with the RAM and the window consumer.
- One sub-module: pix_fifo2, a 2-entry DATA_WIDTH+1 (data, last) FIFO with push/pop/count, async reset.

Test Plan:
- RAM preloaded mem[y][x]=(x+y)&8'hFF; start origin (0,0), pix_ready=1 -> ram_cs first in cycle 1, pix_valid from cycle 3 for 400 consecutive cycles, data 0,1..19,1,2..20,..,38, pix_last on the 400th, done 1 cycle later, busy low after.
- Origin (280,280), ready=1 -> last ram_addr={9'd299,9'd299}, last pix_data=8'd86 (598 mod 256), no err.
- Origin (281,0) and separately (0,281) -> err 1-cycle pulse, ram_cs never asserted, busy stays 0, done never pulses.
- Origin (17,33) with pseudo-random pix_ready (~50%) -> exactly 400 transfers matching the golden raster sequence; outputs stable under stall; ram_cs never asserted with occ=2 and no pop.
- start pulsed again mid-window -> ignored, sequence unaffected. rst asserted after transfer 100 -> all outputs 0 asynchronously. Then start (5,5) -> clean 400-pixel sequence starting at 8'd10.
- Across all tests -> ram_we observed 0 at every cycle.

Source files
------------

// File: rtl/ram_window_reader_pkg.sv
// Shared types and default geometry for the ipgu pixel RAM window reader.
package ram_window_reader_pkg;

    // Defaults shared with the pixel RAM and the window consumer.
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_DEPTH_X    = 300;
    localparam int unsigned DEF_DEPTH_Y    = 300;
    localparam int unsigned DEF_WIN_W      = 20;
    localparam int unsigned DEF_WIN_H      = 20;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } state_e;

    // Counter width that stays at least 1 bit for tiny ranges.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ram_window_reader_if.sv
// RAM read port plus the valid/ready pixel stream of the window reader.
interface ram_window_reader_if
    import ram_window_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH_X = $clog2(DEF_DEPTH_X),
    parameter int unsigned ADDR_WIDTH_Y = $clog2(DEF_DEPTH_Y)
);
    logic [ADDR_WIDTH_Y+ADDR_WIDTH_X-1:0] ram_addr;
    logic                                 ram_cs;
    logic                                 ram_we;
    logic [DATA_WIDTH-1:0]                ram_rdData;
    logic [DATA_WIDTH-1:0]                pix_data;
    logic                                 pix_valid;
    logic                                 pix_ready;
    logic                                 pix_last;

    // Reader side: drives the RAM port and the pixel stream.
    modport master (
        output ram_addr, ram_cs, ram_we,
        input  ram_rdData,
        output pix_data, pix_valid, pix_last,
        input  pix_ready
    );

    // Environment side: RAM and downstream consumer.
    modport slave (
        input  ram_addr, ram_cs, ram_we,
        output ram_rdData,
        input  pix_data, pix_valid, pix_last,
        output pix_ready
    );

endinterface

// File: rtl/ram_window_reader_pix_fifo2.sv
// Two-entry FIFO holding {last, pixel} words between the RAM and the stream.
module ram_window_reader_pix_fifo2
    import ram_window_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;

    // Storage, pointers and occupancy; storage is cleared so reset outputs read 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/ram_window_reader.sv
// Reads a WIN_W x WIN_H window from the pixel RAM in raster order and streams it out.
module ram_window_reader
    import ram_window_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH_X      = DEF_DEPTH_X,
    parameter int unsigned DEPTH_Y      = DEF_DEPTH_Y,
    parameter int unsigned ADDR_WIDTH_X = $clog2(DEPTH_X),
    parameter int unsigned ADDR_WIDTH_Y = $clog2(DEPTH_Y),
    parameter int unsigned WIN_W        = DEF_WIN_W,
    parameter int unsigned WIN_H        = DEF_WIN_H
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH_X-1:0] org_x,
    input  logic [ADDR_WIDTH_Y-1:0] org_y,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    ram_window_reader_if.master     bus
);

    localparam int unsigned NPIX  = WIN_W * WIN_H;
    localparam int unsigned COL_W = clog2_min1(WIN_W);
    localparam int unsigned ROW_W = clog2_min1(WIN_H);
    localparam int unsigned CNT_W = clog2_min1(NPIX);

    state_e                  state_q;
    logic [ADDR_WIDTH_X-1:0] org_x_q;
    logic [ADDR_WIDTH_X-1:0] addr_x_q;
    logic [ADDR_WIDTH_Y-1:0] addr_y_q;
    logic [COL_W-1:0]        col_q;
    logic [ROW_W-1:0]        row_q;
    logic [CNT_W-1:0]        xfer_q;
    logic                    inflight_q;
    logic                    last_inflight_q;

    logic [1:0]              fifo_cnt;
    logic [DATA_WIDTH:0]     fifo_rdata;
    logic                    pop;
    logic [2:0]              occ_after;
    logic                    issue;
    logic                    last_issue;
    logic [ADDR_WIDTH_X:0]   sum_x;
    logic [ADDR_WIDTH_Y:0]   sum_y;
    logic                    in_bounds;

    // Credit: a read may go out only if its data is guaranteed a FIFO slot.
    always_comb begin
        pop        = bus.pix_valid & bus.pix_ready;
        occ_after  = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
        issue      = (state_q == StIssue) && (occ_after < 3'd2);
        last_issue = issue && (col_q == COL_W'(WIN_W - 1)) && (row_q == ROW_W'(WIN_H - 1));
    end

    // Bounds check with one spare bit so the sum cannot wrap.
    always_comb begin
        sum_x     = {1'b0, org_x} + (ADDR_WIDTH_X + 1)'(WIN_W);
        sum_y     = {1'b0, org_y} + (ADDR_WIDTH_Y + 1)'(WIN_H);
        in_bounds = (sum_x <= (ADDR_WIDTH_X + 1)'(DEPTH_X)) &&
                    (sum_y <= (ADDR_WIDTH_Y + 1)'(DEPTH_Y));
    end

    // Control FSM: start acceptance, raster address walk, handshake count, done/err pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            org_x_q         <= '0;
            addr_x_q        <= '0;
            addr_y_q        <= '0;
            col_q           <= '0;
            row_q           <= '0;
            xfer_q          <= '0;
            inflight_q      <= 1'b0;
            last_inflight_q <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            done            <= 1'b0;
            err             <= 1'b0;
            inflight_q      <= issue;
            last_inflight_q <= last_issue;
            if (pop) begin
                xfer_q <= xfer_q + CNT_W'(1);
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (in_bounds) begin
                            org_x_q  <= org_x;
                            addr_x_q <= org_x;
                            addr_y_q <= org_y;
                            col_q    <= '0;
                            row_q    <= '0;
                            xfer_q   <= '0;
                            busy     <= 1'b1;
                            state_q  <= StIssue;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (issue) begin
                        // The final address stays on ram_addr through the drain.
                        if (last_issue) begin
                            state_q <= StDrain;
                        end else if (col_q == COL_W'(WIN_W - 1)) begin
                            col_q    <= '0;
                            row_q    <= row_q + ROW_W'(1);
                            addr_x_q <= org_x_q;
                            addr_y_q <= addr_y_q + ADDR_WIDTH_Y'(1);
                        end else begin
                            col_q    <= col_q + COL_W'(1);
                            addr_x_q <= addr_x_q + ADDR_WIDTH_X'(1);
                        end
                    end
                end
                StDrain: begin
                    // Popping the tagged final pixel implies the buffer and pipe are empty.
                    if (pop && fifo_rdata[DATA_WIDTH]) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    ram_window_reader_pix_fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .wdata ({last_inflight_q, bus.ram_rdData}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_cnt)
    );

    assign bus.ram_cs    = issue;
    assign bus.ram_we    = 1'b0;
    assign bus.ram_addr  = {addr_y_q, addr_x_q};
    assign bus.pix_valid = (fifo_cnt != 2'd0);
    assign bus.pix_data  = fifo_rdata[DATA_WIDTH-1:0];
    assign bus.pix_last  = bus.pix_valid && (xfer_q == CNT_W'(NPIX - 1));

endmodule

// File: tb/tb_ram_window_reader.sv
// Self-checking bench for ram_window_reader with a behavioural RAM and raster model.
module tb_ram_window_reader;
    import ram_window_reader_pkg::*;

    localparam int WW = 20;
    localparam int WH = 20;
    localparam int NP = WW * WH;

    typedef struct {
        int ox;
        int oy;
        int mode;      // 1: ready high, 2: random ready
        bit exp_err;
        int exp_last;  // final pixel value
        bit lat;       // check start-up latency and back-to-back streaming
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [8:0] org_x = '0;
    logic [8:0] org_y = '0;
    logic       busy, done, err;

    ram_window_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH_X(9), .ADDR_WIDTH_Y(9)) bus ();

    ram_window_reader #(
        .DATA_WIDTH (8),
        .DEPTH_X    (300),
        .DEPTH_Y    (300),
        .WIN_W      (WW),
        .WIN_H      (WH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .org_x (org_x),
        .org_y (org_y),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function automatic logic [7:0] pix_at(input int x, input int y);
        return 8'((x + y) % 256);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Behavioural RAM: one-cycle registered read, output held while cs is low.
    always @(posedge clk) begin
        if (bus.ram_cs === 1'b1)
            bus.ram_rdData <= pix_at(int'(bus.ram_addr[8:0]), int'(bus.ram_addr[17:9]));
    end

    // Ready driver.
    int ready_mode = 0;
    initial begin
        bus.pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       bus.pix_ready = 1'b1;
                2:       bus.pix_ready = 1'($urandom_range(0, 1));
                default: bus.pix_ready = 1'b0;
            endcase
        end
    end

    // Monitor state.
    int ncyc = 0, start_cyc, first_cs, first_valid, last_valid, valid_cyc, cs_cnt;
    int done_cnt, done_cyc, err_cnt, busy_seen, last_xfer_cyc;
    int stall_bad, credit_bad, issued, xfered;
    int we_bad = 0, oob_bad = 0;
    bit mark_start = 0;
    bit prev_stall = 0;
    logic [7:0] prev_data;
    logic prev_last;
    logic [17:0] last_addr;
    logic [8:0] got_q [$];
    logic [7:0] exp_q [$];

    task automatic clear_mon();
        start_cyc = -100; first_cs = -1; first_valid = -1; last_valid = -1; valid_cyc = 0;
        cs_cnt = 0; done_cnt = 0; done_cyc = -1; err_cnt = 0; busy_seen = 0;
        last_xfer_cyc = -1; stall_bad = 0; credit_bad = 0; issued = 0; xfered = 0;
        last_addr = '0; got_q.delete();
    endtask

    initial begin
        clear_mon();
        forever begin
            @(negedge clk);
            ncyc++;
            if (bus.ram_we !== 1'b0) we_bad++;
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (mark_start && start) start_cyc = ncyc;
                if (busy) busy_seen = 1;
                if (done) begin done_cnt++; done_cyc = ncyc; end
                if (err) err_cnt++;
                // Reads outstanding = issued but not yet handed to the consumer.
                if (issued - xfered > 2) credit_bad++;
                if (bus.ram_cs && (issued - xfered - int'(bus.pix_valid & bus.pix_ready) >= 2))
                    credit_bad++;
                if (bus.ram_cs) begin
                    cs_cnt++;
                    if (first_cs < 0) first_cs = ncyc;
                    last_addr = bus.ram_addr;
                    if (bus.ram_addr[8:0] >= 300 || bus.ram_addr[17:9] >= 300) oob_bad++;
                end
                if (prev_stall && (!bus.pix_valid || bus.pix_data !== prev_data ||
                                   bus.pix_last !== prev_last))
                    stall_bad++;
                prev_stall = bus.pix_valid & !bus.pix_ready;
                prev_data  = bus.pix_data;
                prev_last  = bus.pix_last;
                if (bus.pix_valid) begin
                    valid_cyc++;
                    if (first_valid < 0) first_valid = ncyc;
                    last_valid = ncyc;
                end
                if (bus.pix_valid && bus.pix_ready) begin
                    got_q.push_back({bus.pix_last, bus.pix_data});
                    last_xfer_cyc = ncyc;
                end
                issued += int'(bus.ram_cs);
                xfered += int'(bus.pix_valid & bus.pix_ready);
            end
        end
    end

    task automatic launch(input int ox, input int oy, input int mode);
        clear_mon();
        ready_mode = mode;
        exp_q.delete();
        for (int y = 0; y < WH; y++)
            for (int x = 0; x < WW; x++)
                exp_q.push_back(pix_at(ox + x, oy + y));
        @(posedge clk);
        #1;
        start = 1'b1; org_x = 9'(ox); org_y = 9'(oy); mark_start = 1;
        @(posedge clk);
        #1;
        start = 1'b0; mark_start = 0;
    endtask

    task automatic wait_end(input string name);
        bit seen = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt > 0 || err_cnt > 0) begin seen = 1; break; end
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
        repeat (10) @(negedge clk);
        #1;
    endtask

    task automatic wait_xfers(input int n);
        for (int k = 0; k < 3000 && got_q.size() < n; k++) begin
            @(negedge clk);
            #1;
        end
        check("reach_xfer_count", (got_q.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic check_window(input string name, input int ox, input int oy,
                                input int exp_last, input bit lat);
        int match = 0;
        int nlast = 0;
        for (int k = 0; k < got_q.size() && k < NP; k++) begin
            if (got_q[k][7:0] == exp_q[k] && got_q[k][8] == (k == NP - 1)) match++;
        end
        foreach (got_q[k]) if (got_q[k][8]) nlast++;
        check({name, "_xfers"}, got_q.size(), NP);
        check({name, "_pixels"}, match, NP);
        check({name, "_last_flags"}, nlast, 1);
        check({name, "_last_data"}, (got_q.size() == NP) ? int'(got_q[NP-1][7:0]) : -1,
              exp_last);
        check({name, "_last_addr"}, int'(last_addr), ((oy + WH - 1) << 9) | (ox + WW - 1));
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_done_timing"}, done_cyc - last_xfer_cyc, 1);
        check({name, "_err"}, err_cnt, 0);
        check({name, "_busy_seen"}, busy_seen, 1);
        check({name, "_busy_after"}, int'(busy), 0);
        check({name, "_reads"}, cs_cnt, NP);
        check({name, "_stall_stable"}, stall_bad, 0);
        check({name, "_credit"}, credit_bad, 0);
        if (lat) begin
            check({name, "_first_cs_cycle"}, first_cs - start_cyc, 1);
            check({name, "_first_valid_cycle"}, first_valid - start_cyc, 3);
            check({name, "_valid_cycles"}, valid_cyc, NP);
            check({name, "_valid_span"}, last_valid - first_valid + 1, NP);
        end
    endtask

    task automatic check_reject(input string name);
        check({name, "_err_pulse"}, err_cnt, 1);
        check({name, "_no_cs"}, cs_cnt, 0);
        check({name, "_no_busy"}, busy_seen, 0);
        check({name, "_no_done"}, done_cnt, 0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{ox: 0,   oy: 0,   mode: 1, exp_err: 0, exp_last: 38, lat: 1};
        vecs[1] = '{ox: 280, oy: 280, mode: 1, exp_err: 0, exp_last: 86, lat: 1};
        vecs[2] = '{ox: 281, oy: 0,   mode: 1, exp_err: 1, exp_last: 0,  lat: 0};
        vecs[3] = '{ox: 0,   oy: 281, mode: 1, exp_err: 1, exp_last: 0,  lat: 0};
        vecs[4] = '{ox: 17,  oy: 33,  mode: 2, exp_err: 0, exp_last: 88, lat: 0};
        vecs[5] = '{ox: 280, oy: 0,   mode: 2, exp_err: 0, exp_last: 62, lat: 0};
        vecs[6] = '{ox: 511, oy: 511, mode: 1, exp_err: 1, exp_last: 0,  lat: 0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_cs", int'(bus.ram_cs), 0);
        check("rst_valid", int'(bus.pix_valid), 0);
        check("rst_addr", int'(bus.ram_addr), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            launch(vecs[i].ox, vecs[i].oy, vecs[i].mode);
            wait_end(nm);
            if (vecs[i].exp_err) check_reject(nm);
            else check_window(nm, vecs[i].ox, vecs[i].oy, vecs[i].exp_last, vecs[i].lat);
        end

        // Random in-bounds origins under random backpressure, plus a random rejection.
        for (int r = 0; r < 2; r++) begin
            int ox, oy;
            ox = $urandom_range(0, 280);
            oy = $urandom_range(0, 280);
            launch(ox, oy, 2);
            wait_end("rand");
            check_window($sformatf("rand%0d", r), ox, oy, int'(pix_at(ox + 19, oy + 19)), 0);
        end
        launch(0, $urandom_range(281, 511), 1);
        wait_end("rand_rej");
        check_reject("rand_rej");

        // Starts while busy (one of them out of bounds) must be ignored.
        launch(40, 50, 1);
        wait_xfers(50);
        @(posedge clk); #1; start = 1'b1; org_x = 9'd0;   org_y = 9'd0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; start = 1'b1; org_x = 9'd290; org_y = 9'd290;
        @(posedge clk); #1; start = 1'b0;
        wait_end("busy_start");
        check_window("busy_start", 40, 50, int'(pix_at(59, 69)), 0);

        // Asynchronous reset mid-window, then a clean restart.
        launch(10, 10, 2);
        wait_xfers(100);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done_err", int'(done) + int'(err), 0);
        check("arst_cs", int'(bus.ram_cs), 0);
        check("arst_addr", int'(bus.ram_addr), 0);
        check("arst_valid", int'(bus.pix_valid), 0);
        check("arst_data", int'(bus.pix_data), 0);
        check("arst_last", int'(bus.pix_last), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        launch(5, 5, 1);
        wait_end("restart");
        check("restart_first_pixel", (got_q.size() > 0) ? int'(got_q[0][7:0]) : -1, 10);
        check_window("restart", 5, 5, 48, 1);

        check("ram_we_never", we_bad, 0);
        check("ram_addr_in_range", oob_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
